data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Handshaked responder that services load/store requests issued by the memory pipeline stage.
- Replaces zero-latency combinational RAM access with a registered, multi-cycle access. A request is accepted, the access is performed after a fixed latency, and a response is held until the pipeline consumes it.
- Owns a byte-addressed big-endian data RAM and performs size selection and sign extension.
- Drives busy so the hazard logic can stall the pipeline.

Parameters:
- WIDTH, 32, data/address width in bits.
- RAM_SIZE, 1024, RAM size in bytes; power of two.
- LATENCY, 2, clock edges from request acceptance to access commit; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = BYTE, 1 = HALF_WORD, 2 = WORD, 3 = reserved.
- req_sign_extend  in  1  load sign-extends BYTE/HALF_WORD results.
- req_address  in  WIDTH  byte address.
- req_write_data  in  WIDTH  store data, right-aligned (BYTE uses [7:0], HALF_WORD uses [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_read_data  out  WIDTH  load result; 0 for stores and errors.
- resp_error  out  1  request was illegal; no RAM side effect.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset:
  - Synchronous, active-high. State goes to IDLE and the latency counter to 0.
  - Outputs after reset: req_ready=1, resp_valid=0, resp_read_data=0, resp_error=0, busy=0.
  - RAM contents are not reset.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture store, size, sign_extend, address and write_data; load counter with LATENCY-1; go to WAIT.
- WAIT:
  - req_ready=0.
  - If counter != 0, decrement it.
  - If counter == 0, commit the access on this edge and go to RESP.
  - Net effect: accept at edge E0, commit at edge E_LATENCY, resp_valid first high in the cycle after E_LATENCY.
- RESP:
  - resp_valid=1. resp_read_data and resp_error are stable until the handshake.
  - On resp_ready, go to IDLE; resp_valid=0 the next cycle.
  - A new request is never accepted in the same cycle as the response handshake.
  - Minimum request period is LATENCY+2 cycles.
- Error check (evaluated at commit):
  - resp_error=1 if any of the following hold:
    - size == 3;
    - HALF_WORD with address[0] != 0;
    - WORD with address[1:0] != 0;
    - address + bytes - 1 >= RAM_SIZE.
  - On error: no RAM write, and resp_read_data=0.
- Byte order is big-endian. The byte at the lowest address is most significant:
  - WORD: ram[a]=wd[31:24], ram[a+1]=wd[23:16], ram[a+2]=wd[15:8], ram[a+3]=wd[7:0].
  - HALF_WORD: ram[a]=wd[15:8], ram[a+1]=wd[7:0].
  - BYTE: ram[a]=wd[7:0].
- Store: writes only the addressed bytes at the commit edge. resp_read_data=0.
- Load:
  - Result is right-aligned and registered at commit.
  - Upper bits are zero-filled, or filled with bit 7 (BYTE) / bit 15 (HALF_WORD) when sign_extend=1.
  - sign_extend is ignored for WORD.
- Ordering: a load accepted after a store's response observes the stored data.
- Inputs are don't-care outside of IDLE, and req_* changes after acceptance are ignored.
- Reset mid-operation:
  - In WAIT, a store not yet committed is discarded and the RAM is unchanged.
  - In RESP, the response is dropped.
- resp_ready asserted while resp_valid=0 has no effect.

Test Plan:
- WORD store then load, LATENCY=2: store addr 0x10, data 0x11223344, with resp_ready tied to 1.
  - Store response arrives 3 cycles after acceptance with error=0.
  - ram[0x10..0x13] = 11,22,33,44.
  - A WORD load from 0x10 returns 0x11223344.
- Sub-word loads on ram[0x20..0x21] = 0x80,0x7F:
  - BYTE load, sign_extend=1 -> 0xFFFFFF80; sign_extend=0 -> 0x00000080.
  - HALF_WORD load from 0x20, sign_extend=1 -> 0xFFFF807F.
  - BYTE load from 0x21, sign_extend=1 -> 0x0000007F.
- Errors, each with resp_error=1, resp_read_data=0 and no RAM change:
  - WORD store to 0x12 with 0xDEADBEEF;
  - HALF_WORD load from 0x21;
  - size=3;
  - WORD load from 0x3FE (RAM_SIZE=1024).
- Response backpressure: hold resp_ready=0 for 5 cycles.
  - resp_valid stays 1 with stable data; req_ready stays 0; req_valid is ignored.
  - Raise resp_ready: IDLE on the next cycle, busy=0, req_ready=1.
- Reset mid-WAIT: issue a BYTE store of 0xAA to 0x30 (prior ram[0x30]=0x55) and pulse rst for 1 cycle during WAIT.
  - No response is produced; all outputs are at reset values.
  - A subsequent load from 0x30 returns 0x00000055.
- Latency sweep, LATENCY=1 and LATENCY=4: cycles from acceptance to resp_valid equal LATENCY+1, and busy is high for exactly that span plus the RESP cycles.

Source files
------------

// File: rtl/data_memory_responder.sv
// Handshaked load/store responder with fixed access latency over a byte-addressed,
// big-endian data RAM. Size selection, alignment/range checking and sign extension.
module data_memory_responder #(
   parameter int WIDTH    = 32,
   parameter int RAM_SIZE = 1024,
   parameter int LATENCY  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_store,
   input  logic [1:0]       req_size,
   input  logic             req_sign_extend,
   input  logic [WIDTH-1:0] req_address,
   input  logic [WIDTH-1:0] req_write_data,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_read_data,
   output logic             resp_error,
   output logic             busy
);
   localparam int AW   = $clog2(RAM_SIZE);
   localparam int ROWS = RAM_SIZE / 4;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [3:0]       r_cnt;
   logic             r_store;
   logic [1:0]       r_size;
   logic             r_sign;
   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] r_wdata;
   logic             r_error;

   logic             w_commit;
   logic             w_err;
   logic [1:0]       w_extra;
   logic [WIDTH:0]   w_last;
   logic [AW-3:0]    w_row;
   logic [31:0]      w_rd;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [WIDTH-1:0] w_fmt;

   // Reset wins over a pending commit so an interrupted store leaves the RAM untouched.
   assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0) && !rst;
   assign w_row    = r_addr[AW-1:2];

   always_comb begin
      case (r_size)
         2'd1:    w_extra = 2'd1;
         2'd2:    w_extra = 2'd3;
         default: w_extra = 2'd0;
      endcase
   end

   assign w_last = {1'b0, r_addr} + (WIDTH+1)'(w_extra);
   assign w_err  = (r_size == 2'd3)
                || ((r_size == 2'd1) && r_addr[0])
                || ((r_size == 2'd2) && (r_addr[1:0] != 2'd0))
                || (w_last >= (WIDTH+1)'(RAM_SIZE));

   // One byte lane per bank; lane 0 holds the most significant (lowest-address) byte.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] r_bank [ROWS];
      logic [7:0] r_rd;
      logic       w_we;
      logic [7:0] w_wd;

      always_comb begin
         w_we = 1'b0;
         w_wd = r_wdata[7:0];
         case (r_size)
            2'd0: w_we = (r_addr[1:0] == LANE);
            2'd1: begin
               w_we = (r_addr[1] == LANE[1]);
               w_wd = LANE[0] ? r_wdata[7:0] : r_wdata[15:8];
            end
            2'd2: begin
               w_we = 1'b1;
               w_wd = r_wdata[8*(3-gi) +: 8];
            end
            default: w_we = 1'b0;
         endcase
      end

      always_ff @(posedge clk) begin
         if (w_commit && r_store && !w_err && w_we)
            r_bank[w_row] <= w_wd;
         if (w_commit)
            r_rd <= r_bank[w_row];
      end

      assign w_rd[8*(3-gi) +: 8] = r_rd;
   end

   always_comb begin
      case (r_addr[1:0])
         2'd0:    w_byte = w_rd[31:24];
         2'd1:    w_byte = w_rd[23:16];
         2'd2:    w_byte = w_rd[15:8];
         default: w_byte = w_rd[7:0];
      endcase
      w_half = r_addr[1] ? w_rd[15:0] : w_rd[31:16];
      case (r_size)
         2'd0:    w_fmt = {{(WIDTH-8){r_sign & w_byte[7]}}, w_byte};
         2'd1:    w_fmt = {{(WIDTH-16){r_sign & w_half[15]}}, w_half};
         default: w_fmt = WIDTH'(w_rd);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (req_valid) w_state_next = S_WAIT;
         S_WAIT:  if (r_cnt == 4'd0) w_state_next = S_RESP;
         S_RESP:  if (resp_ready) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready      = (r_state == S_IDLE);
      resp_valid     = (r_state == S_RESP);
      busy           = (r_state != S_IDLE);
      resp_error     = (r_state == S_RESP) && r_error;
      resp_read_data = ((r_state == S_RESP) && !r_store && !r_error) ? w_fmt : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= 4'd0;
         r_error <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (req_valid) begin
               r_store <= req_store;
               r_size  <= req_size;
               r_sign  <= req_sign_extend;
               r_addr  <= req_address;
               r_wdata <= req_write_data;
               r_cnt   <= 4'(LATENCY - 1);
            end
            S_WAIT: begin
               if (r_cnt != 4'd0)
                  r_cnt <= r_cnt - 4'd1;
               else
                  r_error <= w_err;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: directed requests push expected responses, a monitor pops on handshake.
module tb_data_memory_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_sign_extend = 1'b0;
   logic [31:0] req_address = '0;
   logic [31:0] req_write_data = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_read_data;
   logic        resp_error;
   logic        busy;

   logic        sw_valid [2];
   logic        sw_ready [2];
   logic        sw_rvalid [2];
   logic [31:0] sw_rdata [2];
   logic        sw_error [2];
   logic        sw_busy [2];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int accept_cyc = 0;
   logic prev_valid = 1'b0;
   logic [32:0] exp_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_memory_responder #(.WIDTH(32), .RAM_SIZE(1024), .LATENCY(2)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_store(req_store), .req_size(req_size), .req_sign_extend(req_sign_extend),
      .req_address(req_address), .req_write_data(req_write_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_read_data(resp_read_data),
      .resp_error(resp_error), .busy(busy)
   );

   for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
      localparam int LAT = (gi == 0) ? 1 : 4;
      data_memory_responder #(.WIDTH(32), .RAM_SIZE(1024), .LATENCY(LAT)) u_sw (
         .clk(clk), .rst(rst), .req_valid(sw_valid[gi]), .req_ready(sw_ready[gi]),
         .req_store(1'b1), .req_size(2'd2), .req_sign_extend(1'b0),
         .req_address(32'h4), .req_write_data(32'h01020304),
         .resp_valid(sw_rvalid[gi]), .resp_ready(1'b1), .resp_read_data(sw_rdata[gi]),
         .resp_error(sw_error[gi]), .busy(sw_busy[gi])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Monitor: latency of each response and scoreboard comparison on handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (resp_valid && !prev_valid)
            chk("latency", 32'(cyc - accept_cyc), 32'd3);
         if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               chk("resp_data", resp_read_data, e[31:0]);
               chk("resp_error", {31'd0, resp_error}, {31'd0, e[32]});
            end
         end
      end
      prev_valid = resp_valid;
   end

   task automatic issue(input logic st, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ee, input bit expect_resp);
      int n;
      @(posedge clk); #1;
      req_store = st; req_size = sz; req_sign_extend = sx;
      req_address = a; req_write_data = wd; req_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready && n < 50);
      if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
      accept_cyc = cyc;
      if (expect_resp) exp_q.push_back({ee, ed});
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write_data = 32'hFFFF_FFFF;
      req_address = 32'h0000_0001;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || exp_q.size() != 0) && n < 50);
      if (n >= 50) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic txn(input logic st, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee);
      issue(st, sz, sx, a, wd, ed, ee, 1'b1);
      wait_idle();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_resp_data"}, resp_read_data, 32'd0);
      chk({tag, "_resp_error"}, {31'd0, resp_error}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic sweep(input int i, input int lat);
      int n, first, busy_n;
      bit seen;
      @(posedge clk); #1;
      sw_valid[i] = 1'b1;
      @(negedge clk);
      chk("sweep_ready", {31'd0, sw_ready[i]}, 32'd1);
      @(posedge clk); #1;
      sw_valid[i] = 1'b0;
      n = 0; first = 0; busy_n = 0; seen = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (sw_busy[i]) busy_n++;
         if (sw_rvalid[i] && !seen) begin
            seen = 1;
            first = n;
            chk("sweep_store_data", sw_rdata[i], 32'd0);
            chk("sweep_store_err", {31'd0, sw_error[i]}, 32'd0);
         end
         if (seen && !sw_busy[i]) break;
      end
      chk("sweep_seen", {31'd0, seen}, 32'd1);
      chk("sweep_latency", 32'(first), 32'(lat + 1));
      chk("sweep_busy_cycles", 32'(busy_n), 32'(lat + 1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      sw_valid[0] = 1'b0;
      sw_valid[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("reset");

      // Word store, then big-endian byte placement and word readback.
      txn(1, 2'd2, 0, 32'h10, 32'h11223344, 32'h0, 0);
      txn(0, 2'd2, 0, 32'h10, 32'h0, 32'h11223344, 0);
      txn(0, 2'd0, 0, 32'h10, 32'h0, 32'h11, 0);
      txn(0, 2'd0, 0, 32'h11, 32'h0, 32'h22, 0);
      txn(0, 2'd0, 0, 32'h12, 32'h0, 32'h33, 0);
      txn(0, 2'd0, 1, 32'h13, 32'h0, 32'h44, 0);

      // Sub-word loads and sign extension.
      txn(1, 2'd0, 0, 32'h20, 32'h12345680, 32'h0, 0);
      txn(1, 2'd0, 0, 32'h21, 32'hABCDEF7F, 32'h0, 0);
      txn(0, 2'd0, 1, 32'h20, 32'h0, 32'hFFFFFF80, 0);
      txn(0, 2'd0, 0, 32'h20, 32'h0, 32'h00000080, 0);
      txn(0, 2'd1, 1, 32'h20, 32'h0, 32'hFFFF807F, 0);
      txn(0, 2'd1, 0, 32'h20, 32'h0, 32'h0000807F, 0);
      txn(0, 2'd0, 1, 32'h21, 32'h0, 32'h0000007F, 0);

      // Illegal requests: no data, error flag, RAM unchanged.
      txn(1, 2'd2, 0, 32'h12, 32'hDEADBEEF, 32'h0, 1);
      txn(0, 2'd1, 1, 32'h21, 32'h0, 32'h0, 1);
      txn(1, 2'd3, 0, 32'h10, 32'hCAFEF00D, 32'h0, 1);
      txn(0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1);
      txn(0, 2'd2, 0, 32'h3FE, 32'h0, 32'h0, 1);
      txn(0, 2'd2, 0, 32'h400, 32'h0, 32'h0, 1);
      txn(0, 2'd2, 0, 32'h10, 32'h0, 32'h11223344, 0);

      // Top-of-RAM boundary accesses that are legal.
      txn(1, 2'd2, 0, 32'h3FC, 32'hA1B2C3D4, 32'h0, 0);
      txn(0, 2'd2, 0, 32'h3FC, 32'h0, 32'hA1B2C3D4, 0);
      txn(0, 2'd1, 1, 32'h3FE, 32'h0, 32'hFFFFC3D4, 0);
      txn(0, 2'd0, 0, 32'h3FF, 32'h0, 32'h000000D4, 0);

      // Response backpressure with a competing request held on the input.
      resp_ready = 1'b0;
      issue(0, 2'd2, 0, 32'h10, 32'h0, 32'h11223344, 0, 1'b1);
      begin
         int n;
         n = 0;
         while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("bp_valid_seen", {31'd0, resp_valid}, 32'd1);
      end
      @(posedge clk); #1;
      req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2;
      req_address = 32'h10; req_write_data = 32'h0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
         chk("bp_resp_data", resp_read_data, 32'h11223344);
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("bp_after_busy", {31'd0, busy}, 32'd0);
      chk("bp_after_req_ready", {31'd0, req_ready}, 32'd1);
      chk("bp_after_resp_valid", {31'd0, resp_valid}, 32'd0);
      txn(0, 2'd2, 0, 32'h10, 32'h0, 32'h11223344, 0);

      // Reset landing on the commit edge of a byte store.
      txn(1, 2'd0, 0, 32'h30, 32'h55, 32'h0, 0);
      issue(1, 2'd0, 0, 32'h30, 32'hAA, 32'h0, 0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midwait");
      repeat (3) @(negedge clk);
      chk("midwait_no_resp", {31'd0, resp_valid}, 32'd0);
      txn(0, 2'd0, 0, 32'h30, 32'h0, 32'h00000055, 0);

      // Latency sweep on the LATENCY=1 and LATENCY=4 instances.
      sweep(0, 1);
      sweep(1, 4);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
